// File: rtl/mem_stage_unit_pkg.sv
// Shared size codes, RAM column geometry and default widths for the MEM stage.
package mem_stage_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int NB_COL        = 4;
  localparam int COL_WIDTH     = 8;
  localparam int NB_CTR_WB_DEF = 2;
  localparam int NB_REG_DEF    = 5;

  // Load formatting context carried alongside the MEM/WB latch.
  typedef struct packed {
    logic [1:0] offset;
    logic [1:0] size;
    logic       is_unsigned;
    logic       rd_valid;
  } ld_fmt_t;

  // The unused encoding 2'b10 behaves exactly like a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (size == 2'b10) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/mem_stage_unit_if.sv
// EX/MEM request bundle in, MEM/WB result bundle out.
interface mem_stage_unit_if
  import mem_stage_unit_pkg::*;
#(
  parameter int NB_BITS   = 32,
  parameter int NB_REG    = NB_REG_DEF,
  parameter int NB_CTR_WB = NB_CTR_WB_DEF
) ();

  logic [NB_BITS-1:0]   i_addr;
  logic [NB_BITS-1:0]   i_data;
  logic                 i_write;
  logic                 i_read;
  logic [1:0]           i_size;
  logic                 i_unsigned;
  logic [NB_REG-1:0]    i_reg_dst;
  logic [NB_CTR_WB-1:0] i_wb_ctl;

  logic [NB_BITS-1:0]   o_mem_data;
  logic [NB_BITS-1:0]   o_alu_data;
  logic [NB_REG-1:0]    o_reg_dst;
  logic [NB_CTR_WB-1:0] o_wb_ctl;
  logic                 o_exc_misalign;

  modport master (
    output i_addr, i_data, i_write, i_read, i_size, i_unsigned, i_reg_dst, i_wb_ctl,
    input  o_mem_data, o_alu_data, o_reg_dst, o_wb_ctl, o_exc_misalign
  );

  modport slave (
    input  i_addr, i_data, i_write, i_read, i_size, i_unsigned, i_reg_dst, i_wb_ctl,
    output o_mem_data, o_alu_data, o_reg_dst, o_wb_ctl, o_exc_misalign
  );

endinterface

// File: rtl/mem_stage_unit_dp_byte_ram.sv
// Dual-port byte-writable RAM: port A read/write, port B read-only, both read-first.
module dp_byte_ram #(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int NB_DEPTH  = 10
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NB_DEPTH-1:0]           i_addr_a,
  input  logic [NB_COL*COL_WIDTH-1:0]   i_din_a,
  input  logic [NB_COL-1:0]             i_we_a,
  input  logic                          i_en_a,
  output logic [NB_COL*COL_WIDTH-1:0]   o_dout_a,
  input  logic [NB_DEPTH-1:0]           i_addr_b,
  output logic [NB_COL*COL_WIDTH-1:0]   o_dout_b
);

  logic [NB_COL*COL_WIDTH-1:0] mem [2**NB_DEPTH];

  // Array has no reset so it maps onto block RAM; contents survive i_rst.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NB_COL; c++) begin
      if (i_we_a[c]) begin
        mem[i_addr_a][c*COL_WIDTH +: COL_WIDTH] <= i_din_a[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_dout_a <= '0;
      o_dout_b <= '0;
    end else begin
      if (i_en_a) begin
        o_dout_a <= mem[i_addr_a];
      end
      o_dout_b <= mem[i_addr_b];
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// MIPS MEM stage: sub-word store steering, alignment check, load formatting and the MEM/WB latch.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int NB_BITS   = 32,
  parameter int NB_DEPTH  = 10,
  parameter int NB_REG    = NB_REG_DEF,
  parameter int NB_CTR_WB = NB_CTR_WB_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_stage_unit_if.slave     bus,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [NB_DEPTH-1:0] i_dbg_addr,
  output logic [NB_BITS-1:0]  o_dbg_data
);

  localparam int HALF_W = 2 * COL_WIDTH;

  logic [1:0]           addr_off;
  logic [1:0]           size_eff;
  logic                 access;
  logic                 misalign;
  logic                 wr_en;
  logic [NB_DEPTH-1:0]  word_idx;
  logic [NB_BITS-1:0]   st_data;
  logic [NB_COL-1:0]    st_mask;
  logic [NB_COL-1:0]    we_a;
  logic [NB_BITS-1:0]   ram_q;

  logic [NB_BITS-1:0]   lat_alu;
  logic [NB_REG-1:0]    lat_reg;
  logic [NB_CTR_WB-1:0] lat_wb;
  logic                 lat_exc;
  ld_fmt_t              lat_fmt;

  logic [COL_WIDTH-1:0] lane_b;
  logic [HALF_W-1:0]    lane_h;
  logic                 sign_b;
  logic                 sign_h;
  logic [NB_BITS-1:0]   ld_data;

  assign addr_off = bus.i_addr[1:0];
  assign size_eff = eff_size(bus.i_size);
  assign access   = bus.i_read | bus.i_write;
  assign word_idx = bus.i_addr[NB_DEPTH+1:2];

  always_comb begin
    misalign = 1'b0;
    case (size_eff)
      SZ_HALF: misalign = addr_off[0];
      SZ_WORD: misalign = |addr_off;
      default: misalign = 1'b0;
    endcase
    misalign = misalign & access;
  end

  always_comb begin
    st_data = bus.i_data;
    st_mask = '1;
    case (size_eff)
      SZ_BYTE: begin
        st_data = {NB_COL{bus.i_data[COL_WIDTH-1:0]}};
        st_mask = NB_COL'(1) << addr_off;
      end
      SZ_HALF: begin
        st_data = {2{bus.i_data[HALF_W-1:0]}};
        st_mask = {{2{addr_off[1]}}, {2{~addr_off[1]}}};
      end
      default: begin
        st_data = bus.i_data;
        st_mask = '1;
      end
    endcase
  end

  // Stalled stores are re-presented by EX/MEM, so gating here writes each store once.
  assign wr_en = bus.i_write & ~misalign & ~i_stall & ~i_flush;
  assign we_a  = st_mask & {NB_COL{wr_en}};

  dp_byte_ram #(
    .NB_COL    (NB_COL),
    .COL_WIDTH (COL_WIDTH),
    .NB_DEPTH  (NB_DEPTH)
  ) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_addr_a (word_idx),
    .i_din_a  (st_data),
    .i_we_a   (we_a),
    .i_en_a   (~i_stall),
    .o_dout_a (ram_q),
    .i_addr_b (i_dbg_addr),
    .o_dout_b (o_dbg_data)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lat_alu <= '0;
      lat_reg <= '0;
      lat_wb  <= '0;
      lat_exc <= 1'b0;
      lat_fmt <= '0;
    end else if (i_flush) begin
      lat_alu <= '0;
      lat_reg <= '0;
      lat_wb  <= '0;
      lat_exc <= 1'b0;
      lat_fmt <= '0;
    end else if (!i_stall) begin
      lat_alu <= bus.i_addr;
      lat_reg <= bus.i_reg_dst;
      lat_wb  <= misalign ? '0 : bus.i_wb_ctl;
      lat_exc <= misalign;
      lat_fmt <= '{offset:      addr_off,
                   size:        size_eff,
                   is_unsigned: bus.i_unsigned,
                   rd_valid:    bus.i_read & ~misalign};
    end
  end

  always_comb begin
    lane_b = ram_q[COL_WIDTH-1:0];
    case (lat_fmt.offset)
      2'd1:    lane_b = ram_q[COL_WIDTH   +: COL_WIDTH];
      2'd2:    lane_b = ram_q[2*COL_WIDTH +: COL_WIDTH];
      2'd3:    lane_b = ram_q[3*COL_WIDTH +: COL_WIDTH];
      default: lane_b = ram_q[COL_WIDTH-1:0];
    endcase
    lane_h = lat_fmt.offset[1] ? ram_q[HALF_W +: HALF_W] : ram_q[HALF_W-1:0];
    sign_b = lane_b[COL_WIDTH-1] & ~lat_fmt.is_unsigned;
    sign_h = lane_h[HALF_W-1] & ~lat_fmt.is_unsigned;
    case (lat_fmt.size)
      SZ_BYTE: ld_data = {{(NB_BITS-COL_WIDTH){sign_b}}, lane_b};
      SZ_HALF: ld_data = {{(NB_BITS-HALF_W){sign_h}}, lane_h};
      default: ld_data = ram_q;
    endcase
    if (!lat_fmt.rd_valid) begin
      ld_data = '0;
    end
  end

  assign bus.o_mem_data     = ld_data;
  assign bus.o_alu_data     = lat_alu;
  assign bus.o_reg_dst      = lat_reg;
  assign bus.o_wb_ctl       = lat_wb;
  assign bus.o_exc_misalign = lat_exc;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: byte-addressed memory model, per-cycle compare, directed pins plus random traffic.
module tb_mem_stage_unit;
  import mem_stage_unit_pkg::*;

  localparam int NB_BITS   = 32;
  localparam int NB_DEPTH  = 10;
  localparam int NB_REG    = 5;
  localparam int NB_CTR_WB = 2;
  localparam int NBYTES    = 4 * (2 ** NB_DEPTH);

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_stall = 1'b0;
  logic                i_flush = 1'b0;
  logic [NB_DEPTH-1:0] i_dbg_addr = '0;
  logic [NB_BITS-1:0]  o_dbg_data;

  mem_stage_unit_if #(.NB_BITS(NB_BITS), .NB_REG(NB_REG), .NB_CTR_WB(NB_CTR_WB)) bus ();

  mem_stage_unit #(
    .NB_BITS   (NB_BITS),
    .NB_DEPTH  (NB_DEPTH),
    .NB_REG    (NB_REG),
    .NB_CTR_WB (NB_CTR_WB)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .i_stall    (i_stall),
    .i_flush    (i_flush),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  initial forever #5 i_clk = ~i_clk;

  // Reference model: little-endian byte memory plus the expected WB-side values.
  logic [7:0]  mem_b [NBYTES];
  logic [31:0] exp_md, exp_alu, exp_dbg;
  logic [4:0]  exp_reg;
  logic [1:0]  exp_wb;
  logic        exp_exc;
  bit          dbg_known;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_md  = '0;
    exp_alu = '0;
    exp_dbg = '0;
    exp_reg = '0;
    exp_wb  = '0;
    exp_exc = 1'b0;
  endtask

  task automatic model_step();
    int          n, ba, db;
    longint      v;
    bit          mis;
    logic [31:0] dbg_word;
    db = int'(i_dbg_addr) * 4;
    dbg_word = {mem_b[db+3], mem_b[db+2], mem_b[db+1], mem_b[db]};
    if (i_flush) begin
      exp_alu = '0;
      exp_reg = '0;
      exp_wb  = '0;
      exp_exc = 1'b0;
      exp_md  = '0;
    end else if (!i_stall) begin
      n   = (bus.i_size == 2'b00) ? 1 : (bus.i_size == 2'b01) ? 2 : 4;
      ba  = int'(bus.i_addr % 32'(NBYTES));
      mis = (bus.i_read || bus.i_write) && (ba % n != 0);
      exp_alu = bus.i_addr;
      exp_reg = bus.i_reg_dst;
      exp_wb  = mis ? 2'b00 : bus.i_wb_ctl;
      exp_exc = mis;
      if (bus.i_read && !mis) begin
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(mem_b[ba+k]) << (8 * k);
        if (!bus.i_unsigned && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        exp_md = 32'(v);
      end else begin
        exp_md = '0;
      end
      if (bus.i_write && !mis) begin
        for (int k = 0; k < n; k++) mem_b[ba+k] = 8'(bus.i_data >> (8 * k));
      end
    end
    exp_dbg = dbg_word;
  endtask

  task automatic compare_all();
    chk("mem_data", bus.o_mem_data, exp_md);
    chk("alu_data", bus.o_alu_data, exp_alu);
    chk("reg_dst", 32'(bus.o_reg_dst), 32'(exp_reg));
    chk("wb_ctl", 32'(bus.o_wb_ctl), 32'(exp_wb));
    chk("exc_misalign", 32'(bus.o_exc_misalign), 32'(exp_exc));
    if (dbg_known) chk("dbg_data", o_dbg_data, exp_dbg);
  endtask

  task automatic cycle();
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rdst, input logic [1:0] wb,
                       input bit stall, input bit flush);
    bus.i_read     = rd;
    bus.i_write    = wr;
    bus.i_size     = sz;
    bus.i_unsigned = uns;
    bus.i_addr     = addr;
    bus.i_data     = data;
    bus.i_reg_dst  = rdst;
    bus.i_wb_ctl   = wb;
    i_stall        = stall;
    i_flush        = flush;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_data"}, bus.o_mem_data, 32'h0);
    chk({tag, "_alu_data"}, bus.o_alu_data, 32'h0);
    chk({tag, "_reg_dst"}, 32'(bus.o_reg_dst), 32'h0);
    chk({tag, "_wb_ctl"}, 32'(bus.o_wb_ctl), 32'h0);
    chk({tag, "_exc"}, 32'(bus.o_exc_misalign), 32'h0);
    chk({tag, "_dbg"}, o_dbg_data, 32'h0);
  endtask

  initial begin
    logic [31:0] addr;
    drive(0, 0, SZ_WORD, 0, 32'h0, 32'h0, 5'd0, 2'd0, 0, 0);
    for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
    model_reset();
    dbg_known = 0;

    #1 i_rst = 1'b0;
    #11;
    chk_all_zero("reset");
    i_rst = 1'b1;

    // Fill every word so later loads and debug reads have known contents.
    for (int i = 0; i < 2 ** NB_DEPTH; i++) begin
      drive(0, 1, SZ_WORD, 0, 32'(i * 4), $urandom(), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 0, 0);
      cycle();
    end
    dbg_known = 1;

    drive(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 5'd1, 2'd1, 0, 0); cycle();
    drive(1, 0, SZ_WORD, 0, 32'h10, 32'h0, 5'd7, 2'd3, 0, 0); cycle();
    chk("lit_word_load", bus.o_mem_data, 32'hDEADBEEF);
    chk("lit_word_reg", 32'(bus.o_reg_dst), 32'd7);
    chk("lit_word_wb", 32'(bus.o_wb_ctl), 32'd3);

    drive(0, 1, SZ_WORD, 0, 32'h20, 32'h11223344, 5'd1, 2'd1, 0, 0); cycle();
    drive(0, 1, SZ_BYTE, 0, 32'h21, 32'h000000A5, 5'd1, 2'd1, 0, 0); cycle();
    drive(1, 0, SZ_BYTE, 0, 32'h21, 32'h0, 5'd3, 2'd1, 0, 0); cycle();
    chk("lit_byte_signed", bus.o_mem_data, 32'hFFFFFFA5);
    drive(1, 0, SZ_BYTE, 1, 32'h21, 32'h0, 5'd3, 2'd1, 0, 0); cycle();
    chk("lit_byte_unsigned", bus.o_mem_data, 32'h000000A5);
    drive(1, 0, SZ_WORD, 0, 32'h20, 32'h0, 5'd3, 2'd1, 0, 0); cycle();
    chk("lit_byte_lane1_only", bus.o_mem_data, 32'h1122A544);

    drive(0, 1, SZ_HALF, 0, 32'h32, 32'h12348001, 5'd1, 2'd1, 0, 0); cycle();
    drive(1, 0, SZ_HALF, 0, 32'h32, 32'h0, 5'd6, 2'd1, 0, 0); cycle();
    chk("lit_half_signed", bus.o_mem_data, 32'hFFFF8001);
    drive(1, 0, SZ_HALF, 0, 32'h33, 32'h0, 5'd6, 2'd2, 0, 0); cycle();
    chk("lit_misalign_exc", 32'(bus.o_exc_misalign), 32'd1);
    chk("lit_misalign_wb", 32'(bus.o_wb_ctl), 32'd0);
    chk("lit_misalign_data", bus.o_mem_data, 32'h0);
    drive(0, 1, SZ_HALF, 0, 32'h33, 32'h00007777, 5'd6, 2'd2, 0, 0); cycle();
    chk("lit_misalign_store_exc", 32'(bus.o_exc_misalign), 32'd1);
    drive(1, 0, SZ_WORD, 0, 32'h30, 32'h0, 5'd6, 2'd1, 0, 0); cycle();
    chk("lit_half_kept", {16'h0, bus.o_mem_data[31:16]}, 32'h8001);

    drive(0, 1, SZ_WORD, 0, 32'h40, 32'h55555555, 5'd1, 2'd1, 0, 0); cycle();
    drive(0, 0, SZ_WORD, 0, 32'h44, 32'h0, 5'd2, 2'd0, 0, 0); cycle();
    i_dbg_addr = 10'd16;
    drive(0, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 5'd9, 2'd1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lit_stall_alu", bus.o_alu_data, 32'h44);
      chk("lit_stall_reg", 32'(bus.o_reg_dst), 32'd2);
      chk("lit_stall_nowrite", o_dbg_data, 32'h55555555);
    end
    drive(0, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 5'd9, 2'd1, 0, 0); cycle();
    chk("lit_release_alu", bus.o_alu_data, 32'h40);
    chk("lit_dbg_read_first", o_dbg_data, 32'h55555555);
    drive(1, 0, SZ_WORD, 0, 32'h40, 32'h0, 5'd4, 2'd3, 0, 1); cycle();
    chk("lit_flush_wb", 32'(bus.o_wb_ctl), 32'd0);
    chk("lit_flush_data", bus.o_mem_data, 32'h0);
    chk("lit_flush_alu", bus.o_alu_data, 32'h0);
    chk("lit_dbg_after_write", o_dbg_data, 32'hCAFEF00D);
    drive(1, 0, SZ_WORD, 0, 32'h40, 32'h0, 5'd4, 2'd3, 0, 0); cycle();
    chk("lit_stalled_store_data", bus.o_mem_data, 32'hCAFEF00D);

    i_dbg_addr = 10'd0;
    drive(0, 1, SZ_WORD, 0, 32'h1000, 32'h12345678, 5'd1, 2'd1, 0, 0); cycle();
    drive(0, 0, SZ_WORD, 0, 32'h0, 32'h0, 5'd0, 2'd0, 0, 0); cycle();
    chk("lit_wrap_dbg", o_dbg_data, 32'h12345678);

    // Random traffic confined to bytes 0x80..0xFF (upper address bits randomised to exercise wrap).
    for (int i = 0; i < 1500; i++) begin
      addr = ($urandom() & 32'hFFFFF000) | (32'h80 + 32'($urandom_range(0, 127)));
      i_dbg_addr = 10'(32 + $urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: drive(1, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), addr, $urandom(),
                 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
        1: drive(0, 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), addr, $urandom(),
                 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
        default: drive(0, 0, 2'($urandom_range(0, 3)), 0, addr, $urandom(),
                       5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
      endcase
      cycle();
    end

    // Asynchronous reset in the middle of a load, away from any clock edge.
    i_dbg_addr = 10'd4;
    drive(1, 0, SZ_WORD, 0, 32'h10, 32'h0, 5'd5, 2'd3, 0, 0);
    @(posedge i_clk);
    #3 i_rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #2 i_rst = 1'b1;
    model_reset();
    cycle();
    chk("lit_ram_survives_reset", bus.o_mem_data, 32'hDEADBEEF);
    chk("lit_dbg_survives_reset", o_dbg_data, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
